// File: rtl/display_arbiter_pkg.sv
// Shared types and helpers for the three-requester display arbiter.
// Holds the FSM state encoding, the requester count and the round-robin pick.
package display_arbiter_pkg;

    localparam int NUM_REQ = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SERVE = 2'd1,
        OPEN  = 2'd2
    } state_t;

    // First set bit of r searching from last+1 and wrapping; last itself is checked last.
    function automatic logic [1:0] rr_pick(input logic [NUM_REQ-1:0] r, input logic [1:0] last);
        logic [1:0] res;
        int         j;
        res = last;
        for (int k = NUM_REQ; k >= 1; k--) begin
            j = (int'(last) + k) % NUM_REQ;
            if (r[j]) res = 2'(j);
        end
        return res;
    endfunction

    function automatic logic [NUM_REQ-1:0] idx2oh(input logic [1:0] i);
        logic [NUM_REQ-1:0] one;
        one = {{(NUM_REQ-1){1'b0}}, 1'b1};
        return one << i;
    endfunction

endpackage

// File: rtl/display_arbiter_tick_gen.sv
// Free-running divider: tick is high for one clk cycle every TICK_DIV cycles.
// Latency: first tick on the TICK_DIV-th rising edge after reset; no backpressure.
module tick_gen #(
    parameter int TICK_DIV = 50000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int TD = (TICK_DIV < 1) ? 1 : TICK_DIV;
    localparam int CW = (TD > 1) ? $clog2(TD) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TD - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick = (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d = tick ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/display_arbiter.sv
// Round-robin arbiter granting one of three requesters the display, with a minimum hold time.
// Latency: gnt/busy/num/key are registered, one cycle after the inputs that decide them.
module display_arbiter
    import display_arbiter_pkg::*;
#(
    parameter int          TICK_DIV   = 50000,
    parameter int          HOLD_TICKS = 2000,
    parameter logic [15:0] IDLE_NUM   = 16'h0000,
    parameter logic [3:0]  IDLE_KEY   = 4'hF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic [15:0]        num0,
    input  logic [15:0]        num1,
    input  logic [15:0]        num2,
    input  logic [3:0]         key0,
    input  logic [3:0]         key1,
    input  logic [3:0]         key2,
    output logic [15:0]        num,
    output logic [3:0]         key,
    output logic [NUM_REQ-1:0] gnt,
    output logic               busy
);

    // A hold of zero ticks is treated as one tick.
    localparam int HT = (HOLD_TICKS < 1) ? 1 : HOLD_TICKS;
    localparam int HW = $clog2(HT + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HT - 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(HT);

    logic               tick;
    state_t             state_q;
    logic [1:0]         cur_q;
    logic [HW-1:0]      hold_q;
    logic [NUM_REQ-1:0] gnt_q;
    logic               busy_q;
    logic [15:0]        num_q;
    logic [3:0]         key_q;

    logic               cur_drop;
    logic [NUM_REQ-1:0] others;
    logic [NUM_REQ-1:0] pick_src;
    logic               pick_any;
    logic [1:0]         pick_idx;
    logic [15:0]        cur_num;
    logic [3:0]         cur_key;
    logic [15:0]        pick_num;
    logic [3:0]         pick_key;

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    // cur_q doubles as last_granted, so idle arbitration resumes after the previous owner.
    always_comb begin
        cur_drop = ~req[cur_q];
        others   = req & ~idx2oh(cur_q);
        pick_src = (state_q == IDLE) ? req : others;
        pick_any = |pick_src;
        pick_idx = rr_pick(pick_src, cur_q);
        case (cur_q)
            2'd0:    begin cur_num = num0; cur_key = key0; end
            2'd1:    begin cur_num = num1; cur_key = key1; end
            default: begin cur_num = num2; cur_key = key2; end
        endcase
        case (pick_idx)
            2'd0:    begin pick_num = num0; pick_key = key0; end
            2'd1:    begin pick_num = num1; pick_key = key1; end
            default: begin pick_num = num2; pick_key = key2; end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cur_q   <= 2'd2;
            hold_q  <= '0;
            gnt_q   <= '0;
            busy_q  <= 1'b0;
            num_q   <= IDLE_NUM;
            key_q   <= IDLE_KEY;
        end else begin
            num_q <= cur_num;
            key_q <= cur_key;
            case (state_q)
                IDLE: begin
                    num_q <= IDLE_NUM;
                    key_q <= IDLE_KEY;
                    if (pick_any) begin
                        state_q <= SERVE;
                        cur_q   <= pick_idx;
                        hold_q  <= '0;
                        gnt_q   <= idx2oh(pick_idx);
                        busy_q  <= 1'b1;
                        num_q   <= pick_num;
                        key_q   <= pick_key;
                    end
                end
                SERVE: begin
                    // A dropped request wins over a hold-expiry tick in the same cycle.
                    if (cur_drop) begin
                        if (pick_any) begin
                            cur_q    <= pick_idx;
                            hold_q   <= '0;
                            gnt_q    <= idx2oh(pick_idx);
                            num_q    <= pick_num;
                            key_q    <= pick_key;
                        end else begin
                            state_q <= IDLE;
                            gnt_q   <= '0;
                            busy_q  <= 1'b0;
                            num_q   <= IDLE_NUM;
                            key_q   <= IDLE_KEY;
                        end
                    end else if (tick) begin
                        hold_q <= hold_q + 1'b1;
                        if (hold_q == HOLD_LAST) state_q <= OPEN;
                    end
                end
                OPEN: begin
                    if (pick_any) begin
                        state_q <= SERVE;
                        cur_q   <= pick_idx;
                        hold_q  <= '0;
                        gnt_q   <= idx2oh(pick_idx);
                        num_q   <= pick_num;
                        key_q   <= pick_key;
                    end else if (cur_drop) begin
                        state_q <= IDLE;
                        gnt_q   <= '0;
                        busy_q  <= 1'b0;
                        num_q   <= IDLE_NUM;
                        key_q   <= IDLE_KEY;
                    end else if (tick && hold_q != HOLD_MAX) begin
                        hold_q <= hold_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    gnt_q   <= '0;
                    busy_q  <= 1'b0;
                    num_q   <= IDLE_NUM;
                    key_q   <= IDLE_KEY;
                end
            endcase
        end
    end

    assign gnt  = gnt_q;
    assign busy = busy_q;
    assign num  = num_q;
    assign key  = key_q;

endmodule

// File: doc/display_arbiter.md
DISPLAY_ARBITER -- requirements
Module: display_arbiter

Interface
REQ-001 SHALL have parameter TICK_DIV, default 50000: clk cycles per hold tick (1 kHz at 50 MHz).
REQ-002 SHALL have parameter HOLD_TICKS, default 2000: minimum ticks a grant is held before it can be taken away.
REQ-003 SHALL have parameter IDLE_NUM, default 16'h0000: value shown when no requester is granted.
REQ-004 SHALL have parameter IDLE_KEY, default 4'hF: key digit shown when idle.
REQ-005 clk  in  1: single clock; all logic on its rising edge.
REQ-006 rst  in  1: asynchronous, active-high reset.
REQ-007 req  in  3: per-requester request to use the display.
REQ-008 num0, num1, num2  in  16 each: requester i's four-digit value.
REQ-009 key0, key1, key2  in  4 each: requester i's key digit.
REQ-010 num  out  16: value to the display multiplexer.
REQ-011 key  out  4: key digit to the display multiplexer.
REQ-012 gnt  out  3: one-hot grant, or all-zero when idle.
REQ-013 busy  out  1: high whenever gnt is nonzero.

Function
REQ-014 SHALL generate an internal one-cycle tick every TICK_DIV clk cycles, free-running from reset.
REQ-015 SHALL implement the states IDLE, SERVE and OPEN.
REQ-016 IDLE: gnt=0; num=IDLE_NUM; key=IDLE_KEY.
REQ-017 IDLE: when any req bit is set, SHALL grant the round-robin winner, clear hold_cnt and enter SERVE.
REQ-018 Round-robin search SHALL start at (last_granted+1) mod 3 and wrap 2->0.
REQ-019 SERVE: hold_cnt SHALL increment on each tick.
REQ-020 SERVE: on the tick where hold_cnt==HOLD_TICKS-1, SHALL enter OPEN.
REQ-021 SERVE: if the granted req drops, SHALL switch immediately to the next round-robin requester with hold_cnt cleared; if none is pending, SHALL enter IDLE.
REQ-022 OPEN: if any other req is set, SHALL grant the next round-robin requester, clear hold_cnt and enter SERVE.
REQ-023 OPEN: else, if the granted req drops, SHALL enter IDLE; otherwise SHALL remain in OPEN.
REQ-024 When a req drop and the hold-expiry tick occur in the same cycle, the drop SHALL take precedence.
REQ-025 gnt, busy, num and key SHALL be registered, with 1-cycle latency from the decision edge.
REQ-026 While granted, num and key SHALL track the granted requester's live inputs with 1-cycle latency.
REQ-027 hold_cnt SHALL saturate and never wrap.
REQ-028 HOLD_TICKS=0 SHALL behave as HOLD_TICKS=1.

Reset
REQ-029 rst SHALL force IDLE, gnt=0, busy=0, num=IDLE_NUM, key=IDLE_KEY, hold_cnt=0, tick counter=0 and last_granted=2, so requester 0 wins first.
REQ-030 rst asserted mid-grant SHALL drop the grant asynchronously; the arbiter SHALL resume arbitration on the first edge after deassertion.

Structure
REQ-031 A shared package SHALL hold the state enum (IDLE/SERVE/OPEN) and the constant NUM_REQ=3.
REQ-032 The tick counter SHALL be a sub-module tick_gen with parameter TICK_DIV, ports clk, rst and tick.

Verification (TICK_DIV=4, HOLD_TICKS=3)
REQ-033 Reset, then req=3'b001 with num0=16'h1234 -> gnt=001 and num=16'h1234 one cycle after the arbitration edge.
REQ-034 req=3'b011 from IDLE -> gnt=001; once 3 ticks have elapsed (12 cycles), gnt=010; with both still held, gnt=001 after another 3 ticks.
REQ-035 gnt=001, and req0 drops at cycle 2 of SERVE while req2 is set -> gnt=100 on the next cycle, hold restarted.
REQ-036 req0 drops on the same cycle as the hold-expiry tick with no other requesters -> IDLE; num=16'h0000, key=4'hF.
REQ-037 Assert rst while in OPEN with gnt=010 -> gnt=0 immediately, without waiting for a clock edge; after release with req=3'b111 -> gnt=001.
REQ-038 Alone in OPEN with req held for 50 ticks -> gnt unchanged and hold_cnt saturated.
